genesis_audio_mix: RTL



---
 rtl/genesis_audio_mix.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/genesis_audio_mix.sv
// ----------------------------------------------------------------------------
// genesis_audio_mix
//
// Generates the output sample strobe and mixes the filtered stereo FM signal
// with the unsigned PSG level (scaled by a programmable gain). A soft-mute
// ramp scales the mix between silence and full level without clicks. Each
// channel is saturated to 16-bit signed before it goes to its low-pass stage.
//
// Parameters:
//   DIV        clk cycles per output sample (4..1023)
//   RAMP_STEP  gain change per sample while ramping (1..256)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   fm_l/fm_r  signed 16-bit FM samples
//   psg        unsigned PSG level 0..2047
//   psg_gain   PSG gain 0..15 (0 removes the PSG from the mix)
//   mute       1 ramps the output to silence, 0 ramps it to full level
//   sample_ce  one-cycle strobe every DIV clocks
//   out_l/out_r signed 16-bit mixed outputs, held between updates
//   out_valid  one-cycle pulse when out_l/out_r are updated
//   ramp_busy  high while the gain is ramping up or down
// ----------------------------------------------------------------------------
module genesis_audio_mix #(
    parameter int DIV       = 559,
    parameter int RAMP_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] fm_l,
    input  logic [15:0] fm_r,
    input  logic [10:0] psg,
    input  logic [3:0]  psg_gain,
    input  logic        mute,
    output logic        sample_ce,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid,
    output logic        ramp_busy
);

    typedef enum logic [1:0] {
        MUTED  = 2'd0,
        UP     = 2'd1,
        ACTIVE = 2'd2,
        DOWN   = 2'd3
    } ramp_state_t;

    localparam logic [9:0] LAST_COUNT = 10'(DIV - 1);
    localparam logic [9:0] STEP       = 10'(RAMP_STEP);
    localparam logic [8:0] FULL_GAIN  = 9'd256;

    // ------------------------------------------------------------------
    // Sample strobe
    // ------------------------------------------------------------------
    logic [9:0] count;

    assign sample_ce = (count == LAST_COUNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 10'd0;
        end else if (sample_ce) begin
            count <= 10'd0;
        end else begin
            count <= count + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Soft-mute ramp
    // ------------------------------------------------------------------
    ramp_state_t state, state_next;
    logic [8:0]  gain, gain_next;
    logic [9:0]  gain_up;
    logic        busy_next;

    // One extra bit so the sum can exceed full scale before clamping.
    assign gain_up = {1'b0, gain} + STEP;

    // A reversal only flips direction; the gain resumes moving on the
    // following strobe, so the level never jumps.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        case (state)
            MUTED: begin
                gain_next = 9'd0;
                if (!mute) state_next = UP;
            end
            UP: begin
                if (mute) begin
                    state_next = DOWN;
                end else if (gain_up >= {1'b0, FULL_GAIN}) begin
                    gain_next  = FULL_GAIN;
                    state_next = ACTIVE;
                end else begin
                    gain_next = gain_up[8:0];
                end
            end
            ACTIVE: begin
                gain_next = FULL_GAIN;
                if (mute) state_next = DOWN;
            end
            DOWN: begin
                if (!mute) begin
                    state_next = UP;
                end else if ({1'b0, gain} <= STEP) begin
                    gain_next  = 9'd0;
                    state_next = MUTED;
                end else begin
                    gain_next = 9'({1'b0, gain} - STEP);
                end
            end
            default: begin
                state_next = MUTED;
                gain_next  = 9'd0;
            end
        endcase
        busy_next = (state_next == UP) || (state_next == DOWN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= MUTED;
            gain      <= 9'd0;
            ramp_busy <= 1'b0;
        end else if (sample_ce) begin
            state     <= state_next;
            gain      <= gain_next;
            ramp_busy <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Mixing pipeline: capture, multiply, saturate
    // ------------------------------------------------------------------
    logic [15:0]        cap_l, cap_r;
    logic [14:0]        cap_p;
    logic [8:0]         cap_g;
    logic               cap_valid;
    logic signed [17:0] sum_l, sum_r;
    logic signed [26:0] prod_l, prod_r;
    logic signed [26:0] mix_l, mix_r;
    logic               mix_valid;

    // The PSG term is non-negative and at most 30705, so 18 bits cannot
    // overflow, and with the gain capped at 256 the product fits 27 bits.
    assign sum_l  = $signed({{2{cap_l[15]}}, cap_l}) + $signed({3'b000, cap_p});
    assign sum_r  = $signed({{2{cap_r[15]}}, cap_r}) + $signed({3'b000, cap_p});
    assign prod_l = $signed({{9{sum_l[17]}}, sum_l}) * $signed({18'd0, cap_g});
    assign prod_r = $signed({{9{sum_r[17]}}, sum_r}) * $signed({18'd0, cap_g});

    // Divide by 256 with floor rounding, then clamp to the 16-bit range.
    function automatic logic [15:0] saturate16(input logic signed [26:0] m);
        logic signed [26:0] t;
        t = m >>> 8;
        if (t > 27'sd32767) begin
            return 16'h7FFF;
        end else if (t < -27'sd32768) begin
            return 16'h8000;
        end
        return t[15:0];
    endfunction

    // The gain captured here is the value before this strobe's ramp update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_l     <= 16'd0;
            cap_r     <= 16'd0;
            cap_p     <= 15'd0;
            cap_g     <= 9'd0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= sample_ce;
            if (sample_ce) begin
                cap_l <= fm_l;
                cap_r <= fm_r;
                cap_p <= {4'd0, psg} * {11'd0, psg_gain};
                cap_g <= gain;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mix_l     <= 27'sd0;
            mix_r     <= 27'sd0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= cap_valid;
            if (cap_valid) begin
                mix_l <= prod_l;
                mix_r <= prod_r;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_l     <= 16'd0;
            out_r     <= 16'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= mix_valid;
            if (mix_valid) begin
                out_l <= saturate16(mix_l);
                out_r <= saturate16(mix_r);
            end
        end
    end

endmodule
